// File: rtl/maze_pkg.sv
// Shared types and constants for the maze progress controller.
package maze_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int LEVEL_W  = 2;
    localparam int FCNT_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PLAY,
        LEVEL_UP,
        SCARE,
        WIN_ALL
    } state_t;

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (v == {FCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/maze_frame_sampler.sv
// Cursor hit test, frame-end strobe and per-frame sticky seen/wall/goal flags.
module maze_frame_sampler
    import maze_pkg::*;
#(
    parameter int CURSOR_SIZE = 8,
    parameter int V_DISPLAY   = V_ACTIVE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_video_on,
    input  logic [9:0] i_pix_x,
    input  logic [9:0] i_pix_y,
    input  logic       i_graph_on,
    input  logic       i_finalbox_on,
    input  logic [9:0] i_cursor_x,
    input  logic [9:0] i_cursor_y,
    output logic       o_cursor_on,
    output logic       o_frame_end,
    output logic       o_seen,
    output logic       o_wall_hit,
    output logic       o_goal_hit
);

    logic [10:0] w_px, w_py, w_cx0, w_cy0, w_cx1, w_cy1;
    logic [9:0]  r_prev_y;
    logic        r_seen, r_wall, r_goal;

    // 11-bit compare so a cursor near column 1023 does not wrap onto column 0
    assign w_px  = {1'b0, i_pix_x};
    assign w_py  = {1'b0, i_pix_y};
    assign w_cx0 = {1'b0, i_cursor_x};
    assign w_cy0 = {1'b0, i_cursor_y};
    assign w_cx1 = w_cx0 + 11'(CURSOR_SIZE);
    assign w_cy1 = w_cy0 + 11'(CURSOR_SIZE);

    assign o_cursor_on = i_video_on && (w_px >= w_cx0) && (w_px < w_cx1)
                                    && (w_py >= w_cy0) && (w_py < w_cy1);
    assign o_frame_end = (i_pix_y == 10'(V_DISPLAY)) && (r_prev_y != 10'(V_DISPLAY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_y <= '0;
            r_seen   <= 1'b0;
            r_wall   <= 1'b0;
            r_goal   <= 1'b0;
        end else begin
            r_prev_y <= i_pix_y;
            if (o_frame_end) begin
                r_seen <= 1'b0;
                r_wall <= 1'b0;
                r_goal <= 1'b0;
            end else if (o_cursor_on) begin
                r_seen <= 1'b1;
                if (!i_graph_on)   r_wall <= 1'b1;
                if (i_finalbox_on) r_goal <= 1'b1;
            end
        end
    end

    assign o_seen     = r_seen;
    assign o_wall_hit = r_wall;
    assign o_goal_hit = r_goal;

endmodule

// File: rtl/maze_progress_ctrl.sv
// Maze game FSM: per-frame wall/goal evaluation, level advance, scare and win.
// Optional MAZE_LIVES_EN adds a lives counter so wall hits cost a life before scaring.
module maze_progress_ctrl
    import maze_pkg::*;
#(
    parameter int CURSOR_SIZE  = 8,
    parameter int NUM_LEVELS   = 3,
    parameter int V_DISPLAY    = V_ACTIVE,
    parameter int GRACE_FRAMES = 30,
    parameter int LEVEL_FRAMES = 60,
    parameter int SCARE_FRAMES = 180
`ifdef MAZE_LIVES_EN
    ,
    parameter int LIVES        = 3
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic               graph_on,
    input  logic               finalbox_on,
    input  logic [9:0]         cursor_x,
    input  logic [9:0]         cursor_y,
    input  logic               start,
    output logic [LEVEL_W-1:0] level,
    output logic               cursor_on,
    output logic               in_play,
    output logic               level_up,
    output logic               scare,
    output logic               win
`ifdef MAZE_LIVES_EN
    ,
    output logic [1:0]         lives
`endif
);

    state_t              r_state, w_next_state;
    logic [FCNT_W-1:0]   r_fcnt, w_fcnt_inc;
    logic [LEVEL_W-1:0]  r_level, w_level_next;
    logic                w_frame_end, w_seen, w_wall_hit, w_goal_hit, w_wall;
`ifdef MAZE_LIVES_EN
    logic [1:0]          r_lives, w_lives_next;
`endif

    maze_frame_sampler #(
        .CURSOR_SIZE (CURSOR_SIZE),
        .V_DISPLAY   (V_DISPLAY)
    ) u_sampler (
        .clk           (clk),
        .reset         (reset),
        .i_video_on    (video_on),
        .i_pix_x       (pix_x),
        .i_pix_y       (pix_y),
        .i_graph_on    (graph_on),
        .i_finalbox_on (finalbox_on),
        .i_cursor_x    (cursor_x),
        .i_cursor_y    (cursor_y),
        .o_cursor_on   (cursor_on),
        .o_frame_end   (w_frame_end),
        .o_seen        (w_seen),
        .o_wall_hit    (w_wall_hit),
        .o_goal_hit    (w_goal_hit)
    );

    // A frame in which the cursor never appeared is treated as a wall hit
    assign w_wall     = w_wall_hit || !w_seen;
    assign w_fcnt_inc = sat_inc(r_fcnt);

    always_comb begin
        w_next_state = r_state;
        w_level_next = r_level;
`ifdef MAZE_LIVES_EN
        w_lives_next = r_lives;
`endif
        case (r_state)
            IDLE: if (start) w_next_state = ARM;
            ARM: begin
                if (w_frame_end && w_fcnt_inc == FCNT_W'(GRACE_FRAMES)) w_next_state = PLAY;
            end
            PLAY: begin
                if (w_frame_end) begin
                    if (w_wall) begin
`ifdef MAZE_LIVES_EN
                        if (r_lives > 2'd1) begin
                            w_lives_next = r_lives - 2'd1;
                            w_next_state = ARM;
                        end else begin
                            w_next_state = SCARE;
                        end
`else
                        w_next_state = SCARE;
`endif
                    end else if (w_goal_hit) begin
                        w_next_state = (r_level < LEVEL_W'(NUM_LEVELS)) ? LEVEL_UP : WIN_ALL;
                    end
                end
            end
            LEVEL_UP: begin
                if (w_frame_end && w_fcnt_inc == FCNT_W'(LEVEL_FRAMES)) begin
                    w_level_next = r_level + 1'b1;
                    w_next_state = ARM;
                end
            end
            SCARE: begin
                if (w_frame_end && w_fcnt_inc == FCNT_W'(SCARE_FRAMES)) begin
                    w_level_next = LEVEL_W'(1);
                    w_next_state = IDLE;
`ifdef MAZE_LIVES_EN
                    w_lives_next = 2'(LIVES);
`endif
                end
            end
            WIN_ALL: begin
                if (start) begin
                    w_level_next = LEVEL_W'(1);
                    w_next_state = ARM;
`ifdef MAZE_LIVES_EN
                    w_lives_next = 2'(LIVES);
`endif
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, counter and decoded outputs all update on the transition edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_fcnt   <= '0;
            r_level  <= LEVEL_W'(1);
            in_play  <= 1'b0;
            level_up <= 1'b0;
            scare    <= 1'b0;
            win      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_level <= w_level_next;
            if (w_next_state != r_state) r_fcnt <= '0;
            else if (w_frame_end)        r_fcnt <= w_fcnt_inc;
            in_play  <= (w_next_state == ARM) || (w_next_state == PLAY);
            level_up <= (w_next_state == LEVEL_UP);
            scare    <= (w_next_state == SCARE);
            win      <= (w_next_state == WIN_ALL);
        end
    end

`ifdef MAZE_LIVES_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_lives <= 2'(LIVES);
        else       r_lives <= w_lives_next;
    end
    assign lives = r_lives;
`endif

    assign level = r_level;

endmodule

// File: tb/tb_maze_progress_ctrl.sv
// Directed game walkthrough with randomized cursor placement against a frame-level game model.
module tb_maze_progress_ctrl;

    localparam int CS = 8, NL = 3, GR = 30, LF = 60, SF = 180;
    localparam int SCR_W = 640, SCR_H = 480, VD = 480;
    // Maze: one path rectangle with a single-pixel hole, final box in its lower-right corner
    localparam int PX0 = 100, PX1 = 400, PY0 = 100, PY1 = 200;
    localparam int BX0 = 360, BX1 = 400, BY0 = 150, BY1 = 200;
    localparam int HX = 200, HY = 150;
    localparam int M_IDLE = 0, M_ARM = 1, M_PLAY = 2, M_LUP = 3, M_SCARE = 4, M_WIN = 5;

    logic       clk = 1'b0, reset = 1'b1, video_on = 1'b0, graph_on = 1'b0, finalbox_on = 1'b0, start = 1'b0;
    logic [9:0] pix_x = '0, pix_y = '0, cursor_x = '0, cursor_y = '0;
    logic [1:0] level;
    logic       cursor_on, in_play, level_up, scare, win;
`ifdef MAZE_LIVES_EN
    logic [1:0] lives;
    int         m_lives = 3;
`endif

    int n_assert = 0, n_fail = 0;
    int m_mode = M_IDLE, m_cnt = 0, m_level = 1;

    maze_progress_ctrl dut (
        .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .graph_on(graph_on), .finalbox_on(finalbox_on), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .start(start), .level(level), .cursor_on(cursor_on), .in_play(in_play),
        .level_up(level_up), .scare(scare), .win(win)
`ifdef MAZE_LIVES_EN
        , .lives(lives)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".level"},    level,    m_level);
        check({tag, ".in_play"},  in_play,  (m_mode == M_ARM || m_mode == M_PLAY) ? 1 : 0);
        check({tag, ".level_up"}, level_up, (m_mode == M_LUP)   ? 1 : 0);
        check({tag, ".scare"},    scare,    (m_mode == M_SCARE) ? 1 : 0);
        check({tag, ".win"},      win,      (m_mode == M_WIN)   ? 1 : 0);
`ifdef MAZE_LIVES_EN
        check({tag, ".lives"},    lives,    m_lives);
`endif
    endtask

    // Outcome of a frame from rectangle geometry: visible cursor area vs path, hole and box
    function automatic void eval_cursor(input int cx, input int cy, output bit wall, output bit goal);
        int vx0, vx1, vy0, vy1;
        vx0 = cx; vy0 = cy;
        vx1 = (cx + CS > SCR_W) ? SCR_W : cx + CS;
        vy1 = (cy + CS > SCR_H) ? SCR_H : cy + CS;
        if (vx0 >= vx1 || vy0 >= vy1) begin
            wall = 1'b1; goal = 1'b0;
            return;
        end
        wall = !(vx0 >= PX0 && vx1 <= PX1 && vy0 >= PY0 && vy1 <= PY1)
               || (HX >= vx0 && HX < vx1 && HY >= vy0 && HY < vy1);
        goal = (vx0 < BX1 && vx1 > BX0 && vy0 < BY1 && vy1 > BY0);
    endfunction

    task automatic model_frame(input bit wall, input bit goal);
        case (m_mode)
            M_ARM: begin
                m_cnt++;
                if (m_cnt == GR) begin m_mode = M_PLAY; m_cnt = 0; end
            end
            M_PLAY: begin
                if (wall) begin
`ifdef MAZE_LIVES_EN
                    if (m_lives > 1) begin m_lives--; m_mode = M_ARM; end
                    else m_mode = M_SCARE;
`else
                    m_mode = M_SCARE;
`endif
                    m_cnt = 0;
                end else if (goal) begin
                    m_mode = (m_level < NL) ? M_LUP : M_WIN;
                    m_cnt = 0;
                end
            end
            M_LUP: begin
                m_cnt++;
                if (m_cnt == LF) begin m_level++; m_mode = M_ARM; m_cnt = 0; end
            end
            M_SCARE: begin
                m_cnt++;
                if (m_cnt == SF) begin
                    m_level = 1; m_mode = M_IDLE; m_cnt = 0;
`ifdef MAZE_LIVES_EN
                    m_lives = 3;
`endif
                end
            end
            default: ;
        endcase
    endtask

    // scan=1 sweeps a window around the cursor; scan=0 is an empty frame (cursor unseen)
    task automatic frame(input bit scan, input int cx, input int cy, input string tag);
        bit wall, goal, vis, exp_on;
        if (scan) begin
            cursor_x = 10'(cx); cursor_y = 10'(cy);
            for (int y = cy - 2; y < cy + CS + 2; y++) begin
                for (int x = cx - 2; x < cx + CS + 2; x++) begin
                    pix_x = 10'(x); pix_y = 10'(y);
                    vis = (x < SCR_W && y < SCR_H);
                    video_on = vis;
                    graph_on = (x >= PX0 && x < PX1 && y >= PY0 && y < PY1) && !(x == HX && y == HY);
                    finalbox_on = (x >= BX0 && x < BX1 && y >= BY0 && y < BY1);
                    exp_on = vis && x >= cx && x < cx + CS && y >= cy && y < cy + CS;
                    #1;
                    check({tag, ".cursor_on"}, cursor_on, exp_on);
                    tick();
                end
            end
            eval_cursor(cx, cy, wall, goal);
        end else begin
            pix_x = '0; pix_y = '0; video_on = 1'b0;
            tick();
            wall = 1'b1; goal = 1'b0;
        end
        pix_y = 10'(VD); video_on = 1'b0; graph_on = 1'b0; finalbox_on = 1'b0;
        tick();
        model_frame(wall, goal);
        check_outputs(tag);
    endtask

    task automatic short_frames(input int n, input string tag);
        for (int i = 0; i < n; i++) frame(1'b0, 0, 0, tag);
    endtask

    // kind: 0 clean path, 1 goal only, 2 wall+goal, 3 single hole pixel
    task automatic pick(input int kind, output int cx, output int cy);
        bit wall, goal;
        for (int t = 0; t < 200; t++) begin
            case (kind)
                0: begin cx = int'($urandom_range(PX1 - CS, PX0)); cy = int'($urandom_range(PY1 - CS, PY0)); end
                1: begin cx = int'($urandom_range(BX1 - CS, BX0 - CS + 1)); cy = int'($urandom_range(BY1 - CS, BY0 - CS + 1)); end
                2: begin cx = int'($urandom_range(BX1 - 1, BX1 - CS + 1)); cy = int'($urandom_range(BY1 - CS, BY0)); end
                default: begin cx = int'($urandom_range(HX, HX - CS + 1)); cy = int'($urandom_range(HY, HY - CS + 1)); end
            endcase
            eval_cursor(cx, cy, wall, goal);
            if (kind == 0 && !wall && !goal) break;
            if (kind != 0) break;
        end
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_mode == M_IDLE || m_mode == M_WIN) begin
            m_mode = M_ARM; m_cnt = 0; m_level = 1;
`ifdef MAZE_LIVES_EN
            if (m_mode == M_WIN) m_lives = 3;
`endif
        end
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        m_mode = M_IDLE; m_cnt = 0; m_level = 1;
`ifdef MAZE_LIVES_EN
        m_lives = 3;
`endif
        check_outputs(tag);
        tick();
        reset = 1'b0;
        tick();
        check_outputs({tag, "_rel"});
    endtask

    initial begin
        int cx, cy;
        int wrap_px[5];
        tick();
        check_outputs("reset_hold");
        reset = 1'b0;
        tick();
        check_outputs("after_reset");

        // Cursor at the right edge of the 10-bit range must not wrap onto low columns
        wrap_px = '{1019, 1020, 1023, 0, 3};
        cursor_x = 10'd1020; cursor_y = 10'd10; video_on = 1'b1; pix_y = 10'd12;
        foreach (wrap_px[i]) begin
            pix_x = 10'(wrap_px[i]);
            #1;
            check("cursor_wrap", cursor_on, (wrap_px[i] >= 1020) ? 1 : 0);
        end
        pix_x = 10'd1021; pix_y = 10'd18;
        #1;
        check("cursor_ybound", cursor_on, 0);
        video_on = 1'b0;
        short_frames(2, "idle");

        // Grace plus five frames entirely on the path
        pulse_start("start1");
        for (int i = 0; i < GR + 5; i++) begin
            pick(0, cx, cy);
            frame(1'b1, cx, cy, "on_path");
        end
        pick(3, cx, cy);
        frame(1'b1, cx, cy, "hole_hit");
        short_frames(SF / 2, "scare");
        pulse_start("start_in_scare");
        short_frames(SF - SF / 2 + 2, "scare_end");

        // Level 1 goal, then reset in the middle of level 2 play
        pulse_start("start2");
        short_frames(GR, "grace");
        pick(1, cx, cy);
        frame(1'b1, cx, cy, "goal_l1");
        short_frames(LF, "lvlup");
        short_frames(GR, "grace_l2");
        for (int i = 0; i < 2; i++) begin
            pick(0, cx, cy);
            frame(1'b1, cx, cy, "play_l2");
        end
        do_reset("reset_mid_play");

        // Full run to the win state
        pulse_start("start3");
        for (int l = 1; l <= NL; l++) begin
            short_frames(GR, "grace_run");
            pick(1, cx, cy);
            frame(1'b1, cx, cy, "goal_run");
            if (l < NL) short_frames(LF, "lvlup_run");
        end
        short_frames(5, "win_hold");
        pulse_start("restart_win");

        // Wall and goal in one frame: wall wins
        short_frames(GR, "grace_both");
        pick(2, cx, cy);
        frame(1'b1, cx, cy, "wall_and_goal");
        short_frames(SF, "scare2");

        // Cursor fully off screen for a whole play frame
        pulse_start("start4");
        short_frames(GR, "grace_off");
        frame(1'b1, 700, 200, "offscreen");
        short_frames(3, "scare3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
